// File: rtl/ft600_pkg.sv
// Shared types and widths for the FT600 245-sync bus scheduler.
package ft600_pkg;

  localparam int unsigned FT600_DATA_W = 16;
  localparam int unsigned FT600_BE_W   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_OE   = 3'd1,
    RX_DATA = 3'd2,
    TX_DATA = 3'd3,
    TURN    = 3'd4
  } state_t;

  typedef enum logic {
    RX = 1'b0,
    TX = 1'b1
  } dir_t;

endpackage

// File: rtl/ft600_bus_scheduler.sv
// Round-robin sequencer for the shared FT600 bus: RX (FT600 -> RX FIFO) vs TX (TX FIFO -> FT600),
// with OE/RD/WR strobes, a bus-ownership handoff cycle for RX and turnaround idle after every burst.
module ft600_bus_scheduler
  import ft600_pkg::*;
#(
  parameter int unsigned DATA_W      = FT600_DATA_W,
  parameter int unsigned BE_W        = FT600_BE_W,
  parameter int unsigned MAX_BURST   = 256,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ftdi_rxf_n,
  input  logic              ftdi_txe_n,
  output logic              ftdi_oe_n,
  output logic              ftdi_rd_n,
  output logic              ftdi_wr_n,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] pin_data_in,
  input  logic [BE_W-1:0]   pin_be_in,
  output logic [DATA_W-1:0] pin_data_out,
  output logic [BE_W-1:0]   pin_be_out,
  output logic              rx_push,
  output logic [DATA_W-1:0] rx_data,
  output logic [BE_W-1:0]   rx_be,
  input  logic              rx_full,
  output logic              tx_pop,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [BE_W-1:0]   tx_be,
  input  logic              tx_empty,
  output logic [2:0]        bus_state
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);

  state_t        state;
  dir_t          last_dir;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] turn_cnt;

  logic rx_req, tx_req;
  logic rx_beat, tx_beat;
  logic burst_last;

  assign rx_req     = !ftdi_rxf_n && !rx_full;
  assign tx_req     = !ftdi_txe_n && !tx_empty;
  assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));

  assign rx_data   = pin_data_in;
  assign rx_be     = pin_be_in;
  assign bus_state = state;

  // Pin strobes and FIFO handshakes; gated by reset so the bus is released immediately.
  always_comb begin
    ftdi_oe_n    = 1'b1;
    ftdi_rd_n    = 1'b1;
    ftdi_wr_n    = 1'b1;
    bus_oe       = 1'b0;
    rx_push      = 1'b0;
    tx_pop       = 1'b0;
    rx_beat      = 1'b0;
    tx_beat      = 1'b0;
    pin_data_out = '0;
    pin_be_out   = '0;
    if (rst_n) begin
      case (state)
        RX_OE: ftdi_oe_n = 1'b0;
        RX_DATA: begin
          ftdi_oe_n = 1'b0;
          ftdi_rd_n = rx_full;
          rx_beat   = !rx_full && !ftdi_rxf_n;
          rx_push   = rx_beat;
        end
        TX_DATA: begin
          bus_oe       = 1'b1;
          pin_data_out = tx_data;
          pin_be_out   = tx_be;
          ftdi_wr_n    = tx_empty;
          tx_beat      = !tx_empty && !ftdi_txe_n;
          tx_pop       = tx_beat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_dir  <= TX;
      burst_cnt <= '0;
      turn_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_req && tx_req) state <= (last_dir == TX) ? RX_OE : TX_DATA;
          else if (rx_req)      state <= RX_OE;
          else if (tx_req)      state <= TX_DATA;
        end
        RX_OE: state <= RX_DATA;
        RX_DATA: begin
          if (rx_beat) burst_cnt <= burst_cnt + BW'(1);
          if (ftdi_rxf_n || rx_full || (rx_beat && burst_last)) begin
            state     <= TURN;
            last_dir  <= RX;
            burst_cnt <= '0;
            turn_cnt  <= '0;
          end
        end
        TX_DATA: begin
          if (tx_beat) burst_cnt <= burst_cnt + BW'(1);
          if (ftdi_txe_n || tx_empty || (tx_beat && burst_last)) begin
            state     <= TURN;
            last_dir  <= TX;
            burst_cnt <= '0;
            turn_cnt  <= '0;
          end
        end
        TURN: begin
          if (turn_cnt == TW'(TURN_CYCLES - 1)) begin
            state    <= IDLE;
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ft600_bus_scheduler.md
Name: ft600_bus_scheduler

Overview:
Sequences the shared FT600 245-sync bidirectional bus between the receive direction (FT600 to RX FIFO) and the transmit direction (TX FIFO to FT600).
- Generates OE_N, RD_N and WR_N, plus the FPGA-side tristate enable for ftdi_data/ftdi_be.
- Inserts bus turnaround cycles between directions.
- Arbitrates round-robin, with a bounded burst length per grant.
- Sits between the pin-level FT600 interface and the ftdi_clk-domain sync FIFOs, replacing free-running loopback strobing.

Parameters:
- DATA_W, 16, FT600 data bus width.
- BE_W, 2, byte-enable width.
- MAX_BURST, 256, maximum beats per grant before re-arbitration (>=1).
- TURN_CYCLES, 1, idle cycles inserted after every burst (>=1).

Ports:
- clk  in  1  ftdi_clk, 100 MHz, sole clock.
- rst_n  in  1  synchronous, active-low reset.
- ftdi_rxf_n  in  1  FT600 has RX data when low.
- ftdi_txe_n  in  1  FT600 can accept TX data when low.
- ftdi_oe_n  out  1  FT600 output enable, active low.
- ftdi_rd_n  out  1  FT600 read strobe, active low.
- ftdi_wr_n  out  1  FT600 write strobe, active low.
- bus_oe  out  1  high = FPGA drives ftdi_data/ftdi_be.
- pin_data_in  in  DATA_W  sampled ftdi_data.
- pin_be_in  in  BE_W  sampled ftdi_be.
- pin_data_out  out  DATA_W  value driven on ftdi_data.
- pin_be_out  out  BE_W  value driven on ftdi_be.
- rx_push  out  1  write strobe to RX FIFO.
- rx_data  out  DATA_W  RX FIFO write data.
- rx_be  out  BE_W  RX FIFO write byte-enables.
- rx_full  in  1  RX FIFO full.
- tx_pop  out  1  read strobe to TX FIFO (first-word-fall-through).
- tx_data  in  DATA_W  TX FIFO head data.
- tx_be  in  BE_W  TX FIFO head byte-enables.
- tx_empty  in  1  TX FIFO empty.
- bus_state  out  3  current state encoding (debug/LED).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Clock port is `clk`, reset port is `rst_n`.
- Reset values: state = IDLE, last_dir = TX, burst_cnt = 0. While in reset: oe_n = rd_n = wr_n = 1; bus_oe = 0; rx_push = tx_pop = 0.
- States (enum), each with its outputs and transitions:
  - IDLE: all strobes high, bus_oe = 0.
    - Pending conditions: rx_req = !ftdi_rxf_n & !rx_full; tx_req = !ftdi_txe_n & !tx_empty.
    - Both requests: grant the direction opposite to last_dir.
    - Single request: grant it. Grant RX goes to RX_OE; grant TX goes to TX_DATA.
    - Neither request: stay in IDLE.
  - RX_OE: oe_n = 0, rd_n = 1, exactly 1 cycle; then RX_DATA. This is the FT600 bus-ownership handoff.
  - RX_DATA: oe_n = 0; rd_n = rx_full.
    - Beat: rd_n = 0 & rxf_n = 0 in the same cycle.
    - On a beat: rx_push = 1 combinationally; rx_data/rx_be = pin_data_in/pin_be_in; burst_cnt increments.
    - Exit to TURN when rxf_n = 1, rx_full = 1, or a beat makes burst_cnt == MAX_BURST. The exiting beat is still pushed.
  - TX_DATA: bus_oe = 1; pin_data_out/pin_be_out = tx_data/tx_be; wr_n = tx_empty.
    - Beat: wr_n = 0 & txe_n = 0.
    - On a beat: tx_pop = 1 and burst_cnt increments.
    - Exit to TURN when txe_n = 1, tx_empty = 1, or a beat makes burst_cnt == MAX_BURST.
  - TURN: all strobes high, bus_oe = 0, for TURN_CYCLES cycles; then IDLE.
    - On entry: last_dir = direction just served; burst_cnt cleared.
- Outside TX_DATA, pin_data_out and pin_be_out hold 0.
- Latency:
  - First RX beat no earlier than 2 cycles after the IDLE grant cycle.
  - First TX beat in the cycle after the grant.
  - Back-to-back beats at 1 per cycle within a burst.
- Boundaries:
  - rx_full rising mid-burst: rd_n deasserts in the same cycle; no push that cycle; exit to TURN.
  - txe_n rising mid-burst: no pop that cycle; exit to TURN.
  - Same-cycle requests in IDLE: round-robin as defined above; no starvation.
  - A zero-beat grant still passes through TURN.
  - rst_n low in any state: next edge forces IDLE with all strobes high; bus_oe = 0 no later than that edge.
- Widths: burst_cnt is $clog2(MAX_BURST+1) bits; turn_cnt is $clog2(TURN_CYCLES+1) bits; neither wraps.

Decomposition:
- Package `ft600_pkg`:
  - state enum (IDLE, RX_OE, RX_DATA, TX_DATA, TURN).
  - dir_t (RX, TX).
  - FT600_DATA_W = 16, FT600_BE_W = 2.
- No sub-module. The tristate buffer itself stays in the top level, driven by bus_oe.

Test Plan:
- RX only: rxf_n low for 5 cycles, rx_full = 0 -> oe_n low 1 cycle before rd_n; 5 rx_push beats with data 0x0001..0x0005 / be 2'b11 in order; then TURN 1 cycle, IDLE.
- TX only: TX FIFO holds 3 words 0xA5A5, 0x5A5A, 0x1234; txe_n low -> bus_oe high; wr_n low 3 cycles; pin_data_out sequence matches; tx_pop ×3; then TURN.
- Contention: rxf_n and txe_n both low, both FIFOs non-empty/non-full, MAX_BURST = 4 -> RX burst of 4, TURN, TX burst of 4, TURN, RX burst… strictly alternating.
- Backpressure: rx_full asserted after beat 2 of an RX burst -> rd_n high in that same cycle; exactly 2 pushes; TURN entered; no push while full.
- TXE drop: txe_n high after 1 TX beat -> wr_n stays low but no pop; exit to TURN; remaining words retained in FIFO.
- Reset mid-burst: rst_n low during TX_DATA -> next edge: bus_oe = 0, all strobes high, bus_state = IDLE; first grant after release is RX.
